// File: rtl/accel_pkg.sv
// accel_pkg: load FSM encoding and tile geometry helpers shared by the weight loader.
package accel_pkg;
  typedef enum logic [2:0] {IDLE, ACQUIRE, FILL, WRITE, WAIT_DONE} load_state_t;
  function automatic int beats_f(input int tile_width, input int in_width);
    return tile_width / in_width;
  endfunction
  function automatic int tiles_f(input int buffer_width, input int tile_width);
    return buffer_width / tile_width;
  endfunction
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tile_packer.sv
// tile_packer: assembles IN_WIDTH stream beats into one TILE_WIDTH word, beat 0 in the LSBs.
module tile_packer
  import accel_pkg::*;
#(
  parameter int TILE_WIDTH = 256,
  parameter int IN_WIDTH   = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  beat_i,
  input  logic [IN_WIDTH-1:0]   data_i,
  output logic                  last_o,
  output logic [TILE_WIDTH-1:0] tile_o
);
  localparam int BEATS = beats_f(TILE_WIDTH, IN_WIDTH);
  localparam int BW    = cnt_w(BEATS);
  logic [BW-1:0]         beat_cnt_q;
  logic [TILE_WIDTH-1:0] tile_q;
  assign last_o = beat_cnt_q == BW'(BEATS - 1);
  assign tile_o = tile_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      beat_cnt_q <= '0;
      tile_q     <= '0;
    end else if (beat_i) begin
      tile_q[int'(beat_cnt_q)*IN_WIDTH +: IN_WIDTH] <= data_i;
      beat_cnt_q <= last_o ? '0 : beat_cnt_q + 1'b1;
    end
endmodule

// File: rtl/weight_tile_loader.sv
// weight_tile_loader: streams weight beats into tiles and writes full buffers round-robin,
// waiting for a free buffer before each load and tracking per-buffer full flags.
module weight_tile_loader
  import accel_pkg::*;
#(
  parameter int BUFFER_WIDTH = 1024,
  parameter int BUFFER_COUNT = 2,
  parameter int TILE_WIDTH   = 256,
  parameter int IN_WIDTH     = 64
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic [15:0]                     load_count,
  input  logic                            in_valid,
  input  logic [IN_WIDTH-1:0]             in_data,
  output logic                            in_ready,
  output logic                            write_enable,
  output logic [TILE_WIDTH-1:0]           write_data,
  output logic [$clog2(BUFFER_COUNT)-1:0] write_buffer,
  input  logic                            writing_done,
  input  logic                            buf_release,
  input  logic [$clog2(BUFFER_COUNT)-1:0] release_buffer,
  output logic [BUFFER_COUNT-1:0]         buf_full,
  output logic                            busy,
  output logic                            done
);
  localparam int TILES = tiles_f(BUFFER_WIDTH, TILE_WIDTH);
  localparam int TW    = cnt_w(TILES);
  localparam int CW    = $clog2(BUFFER_COUNT);
  load_state_t             state_q;
  logic [CW-1:0]           cur_q;
  logic [TW-1:0]           tile_cnt_q;
  logic [15:0]             loads_left_q;
  logic [BUFFER_COUNT-1:0] buf_full_q;
  logic                    in_ready_q, write_enable_q, busy_q, done_q, beat, last_beat;
  assign beat         = in_valid & in_ready_q;
  assign in_ready     = in_ready_q;
  assign write_enable = write_enable_q;
  assign write_buffer = cur_q;
  assign buf_full     = buf_full_q;
  assign busy         = busy_q;
  assign done         = done_q;
  tile_packer #(.TILE_WIDTH(TILE_WIDTH), .IN_WIDTH(IN_WIDTH)) u_packer (
    .clk     (clk),
    .reset_n (reset_n),
    .beat_i  (beat),
    .data_i  (in_data),
    .last_o  (last_beat),
    .tile_o  (write_data)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q        <= IDLE;
      cur_q          <= '0;
      tile_cnt_q     <= '0;
      loads_left_q   <= '0;
      buf_full_q     <= '0;
      in_ready_q     <= 1'b0;
      write_enable_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      done_q         <= 1'b0;
      write_enable_q <= 1'b0;
      // release first so a same-cycle set of the same flag below takes precedence
      if (buf_release) buf_full_q[release_buffer] <= 1'b0;
      case (state_q)
        IDLE:
          if (start && load_count != 16'd0) begin
            loads_left_q <= load_count;
            busy_q       <= 1'b1;
            state_q      <= ACQUIRE;
          end else if (start) done_q <= 1'b1;
        ACQUIRE:
          if (!buf_full_q[cur_q]) begin
            in_ready_q <= 1'b1;
            state_q    <= FILL;
          end
        FILL:
          if (beat && last_beat) begin
            in_ready_q     <= 1'b0;
            write_enable_q <= 1'b1;
            state_q        <= WRITE;
          end
        WRITE:
          if (tile_cnt_q == TW'(TILES - 1)) begin
            tile_cnt_q <= '0;
            state_q    <= WAIT_DONE;
          end else begin
            tile_cnt_q <= tile_cnt_q + 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= FILL;
          end
        WAIT_DONE:
          if (writing_done) begin
            buf_full_q[cur_q] <= 1'b1;
            cur_q             <= cur_q == CW'(BUFFER_COUNT - 1) ? '0 : cur_q + 1'b1;
            loads_left_q      <= loads_left_q - 16'd1;
            state_q           <= loads_left_q == 16'd1 ? IDLE : ACQUIRE;
            busy_q            <= loads_left_q != 16'd1;
            done_q            <= loads_left_q == 16'd1;
          end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_weight_tile_loader.sv
// tb_weight_tile_loader: directed checks of loading, stalls, buffer back-pressure and reset.
module tb_weight_tile_loader;
  localparam int IW = 64;
  localparam int TW = 256;
  localparam int BC = 2;
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   load_count = '0;
  logic          in_valid = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          in_ready, write_enable, busy, done;
  logic [TW-1:0] write_data;
  logic [0:0]    write_buffer;
  logic          writing_done = 1'b0;
  logic          buf_release = 1'b0;
  logic [0:0]    release_buffer = '0;
  logic [BC-1:0] buf_full;
  int errors = 0, checks = 0, cyc = 0, beat_idx = 0;
  bit stream_en = 1'b0, tog = 1'b0, phase = 1'b0, hs = 1'b0;
  logic [TW-1:0] wdq[$];
  int wbq[$];
  int wcq[$];

  weight_tile_loader dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .load_count     (load_count),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .write_enable   (write_enable),
    .write_data     (write_data),
    .write_buffer   (write_buffer),
    .writing_done   (writing_done),
    .buf_release    (buf_release),
    .release_buffer (release_buffer),
    .buf_full       (buf_full),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // stream source: data is the running beat index, advanced after each accepted beat
  initial forever begin
    @(negedge clk);
    if (hs) beat_idx++;
    phase    = ~phase;
    in_valid = stream_en && (!tog || phase);
    in_data  = IW'(beat_idx);
    hs       = in_valid && in_ready;
  end

  initial forever begin
    @(negedge clk);
    if (write_enable === 1'b1) begin
      wdq.push_back(write_data);
      wbq.push_back(int'(write_buffer));
      wcq.push_back(cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cycle(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chkw(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [TW-1:0] tile(input int b);
    return {IW'(b + 3), IW'(b + 2), IW'(b + 1), IW'(b)};
  endfunction

  // waits for one full buffer (4 tiles) from write index n0, checks it, then acknowledges it
  task automatic expect_load(input int n0, input int base, input int bufi, input bit rel, input string tag);
    int t = 0;
    while (wdq.size() < n0 + 4 && t < 300) begin
      cycle();
      t++;
    end
    chk({tag, "_writes_seen"}, longint'(wdq.size() >= n0 + 4), 1);
    for (int k = 0; k < 4; k++)
      if (n0 + k < wdq.size()) begin
        chkw({tag, "_data"}, wdq[n0+k], tile(base + 4*k));
        chk({tag, "_buf"}, wbq[n0+k], bufi);
      end
    cycle(3);
    chk({tag, "_no_extra"}, wdq.size(), n0 + 4);
    chk({tag, "_wait_ready_busy"}, {in_ready, busy}, 2'b01);
    writing_done   = 1'b1;
    buf_release    = rel;
    release_buffer = 1'(bufi);
    cycle();
    writing_done = 1'b0;
    buf_release  = 1'b0;
  endtask

  initial begin
    int n0, t;
    cycle(2);
    chk("reset_outs", {in_ready, write_enable, busy, done, buf_full, write_buffer}, 0);
    chkw("reset_wdata", write_data, '0);
    reset_n = 1'b1;
    cycle();

    // single load, continuous stream
    beat_idx = 0; stream_en = 1'b1; tog = 1'b0; n0 = wdq.size();
    load_count = 16'd1; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("t1_busy", busy, 1);
    expect_load(n0, 0, 0, 1'b0, "t1");
    chk("t1_buf_full", buf_full, 2'b01);
    chk("t1_done", done, 1);
    chk("t1_idle", busy, 0);
    chk("t1_beats", beat_idx, 16);
    cycle();
    chk("t1_done_pulse", done, 0);
    stream_en = 1'b0;
    buf_release = 1'b1; release_buffer = 1'b0;
    cycle();
    buf_release = 1'b0;
    chk("rel0", buf_full, 2'b00);

    // stalling stream into buffer 1, release colliding with set
    beat_idx = 0; stream_en = 1'b1; tog = 1'b1; n0 = wdq.size();
    load_count = 16'd1; start = 1'b1;
    cycle();
    start = 1'b0;
    expect_load(n0, 0, 1, 1'b1, "t2");
    for (int k = 1; k < 4; k++)
      if (n0 + k < wcq.size()) chk("t2_gap", longint'(wcq[n0+k] - wcq[n0+k-1] >= 8), 1);
    chk("t2_set_wins", buf_full, 2'b10);
    chk("t2_done", done, 1);
    stream_en = 1'b0; tog = 1'b0;
    buf_release = 1'b1; release_buffer = 1'b1;
    cycle();
    buf_release = 1'b0;
    chk("rel1", buf_full, 2'b00);

    // zero-length request
    n0 = wdq.size();
    load_count = 16'd0; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("t3_done", {done, busy}, 2'b10);
    cycle();
    chk("t3_done_pulse", done, 0);
    cycle(5);
    chk("t3_no_writes", wdq.size(), n0);

    // three loads against two buffers, consumer late; start while busy ignored
    beat_idx = 0; stream_en = 1'b1; n0 = wdq.size();
    load_count = 16'd3; start = 1'b1;
    cycle();
    start = 1'b0;
    expect_load(n0, 0, 0, 1'b0, "L1");
    chk("L1_state", {buf_full, done, busy}, 4'b0101);
    expect_load(n0 + 4, 16, 1, 1'b0, "L2");
    chk("L2_full", buf_full, 2'b11);
    load_count = 16'd9; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle(100);
    chk("L3_blocked", {in_ready, busy}, 2'b01);
    chk("L3_no_writes", wdq.size(), n0 + 8);
    chk("L3_no_beats", beat_idx, 32);
    buf_release = 1'b1; release_buffer = 1'b0;
    cycle();
    buf_release = 1'b0;
    expect_load(n0 + 8, 32, 0, 1'b0, "L3");
    chk("L3_end", {buf_full, done, busy}, 4'b1110);
    stream_en = 1'b0;
    buf_release = 1'b1; release_buffer = 1'b1;
    cycle();
    buf_release = 1'b0;
    chk("rel1_again", buf_full, 2'b01);

    // reset in the middle of the second tile
    beat_idx = 0; stream_en = 1'b1;
    load_count = 16'd1; start = 1'b1;
    cycle();
    start = 1'b0;
    t = 0;
    while (beat_idx < 6 && t < 100) begin
      cycle();
      t++;
    end
    chk("t5_reached_6", longint'(beat_idx >= 6), 1);
    n0 = wdq.size();
    reset_n = 1'b0;
    #1;
    chk("t5_rst_outs", {in_ready, write_enable, busy, done, buf_full, write_buffer}, 0);
    chkw("t5_rst_wdata", write_data, '0);
    cycle(2);
    stream_en = 1'b0;
    reset_n = 1'b1;
    cycle(4);
    beat_idx = 100;
    chk("t5_no_write", wdq.size(), n0);
    stream_en = 1'b1;
    load_count = 16'd1; start = 1'b1;
    cycle();
    start = 1'b0;
    expect_load(n0, 100, 0, 1'b0, "t5");
    chk("t5_end", {buf_full, done, busy}, 4'b0110);
    stream_en = 1'b0;
    cycle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
